// File: rtl/alu_mul_pkg.sv
// rtl/alu_mul_pkg.sv - shared FSM states and constants for the ALU-reusing multiply sequencer
package alu_mul_pkg;
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   localparam logic [4:0] ALU_OP_ADD = 5'b00100;
   localparam int         MUL_ITER   = 16;
endpackage

// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - 16x16 multiply sequencer driving the shared ALU adder; ALU_MUL_ZERO_SKIP_EN enables zero-operand early done
module alu_mul_seq
   import alu_mul_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sign,
   input  logic [WIDTH-1:0] mcand,
   input  logic [WIDTH-1:0] mplier,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] prod_hi,
   output logic [WIDTH-1:0] prod_lo,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [4:0]       alu_op,
   output logic             alu_cin,
   output logic             alu_invb,
   output logic             alu_sign,
   input  logic [WIDTH-1:0] alu_out,
   input  logic             alu_ofl
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MUL_ITER - 1);

   state_t           state;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] q;
   logic             q_1;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] m;
   logic             sgn;

   logic             do_add;
   logic [WIDTH-1:0] sum;
   logic             top_bit;
   logic             skip;

`ifdef ALU_MUL_ZERO_SKIP_EN
   assign skip = (mcand == '0) || (mplier == '0);
`else
   assign skip = 1'b0;
`endif

   assign alu_a    = acc;
   assign alu_b    = m;
   assign alu_op   = ALU_OP_ADD;
   assign alu_sign = sgn;
   assign prod_hi  = acc;
   assign prod_lo  = q;

   // Signed add/sub may overflow the 16-bit sum; the true sign is recovered from the ALU overflow flag.
   always_comb begin
      do_add   = 1'b0;
      alu_invb = 1'b0;
      alu_cin  = 1'b0;
      if (state == CALC) begin
         if (sgn) begin
            case ({q[0], q_1})
               2'b01: do_add = 1'b1;
               2'b10: begin
                  do_add   = 1'b1;
                  alu_invb = 1'b1;
                  alu_cin  = 1'b1;
               end
               default: do_add = 1'b0;
            endcase
         end else begin
            do_add = q[0];
         end
      end
      sum = do_add ? alu_out : acc;
      if (sgn)
         top_bit = do_add ? (alu_out[WIDTH-1] ^ alu_ofl) : acc[WIDTH-1];
      else
         top_bit = do_add & alu_ofl;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         acc   <= '0;
         q     <= '0;
         q_1   <= 1'b0;
         cnt   <= '0;
         m     <= '0;
         sgn   <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               busy <= 1'b0;
               if (start) begin
                  m   <= mcand;
                  sgn <= sign;
                  acc <= '0;
                  q_1 <= 1'b0;
                  cnt <= '0;
                  if (skip) begin
                     q     <= '0;
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     q     <= mplier;
                     state <= CALC;
                     busy  <= 1'b1;
                  end
               end else begin
                  state <= IDLE;
               end
            end
            CALC: begin
               {acc, q, q_1} <= {top_bit, sum, q};
               cnt           <= cnt + CNT_W'(1);
               if (cnt == LAST_CNT) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_mul_seq.sv
// tb/tb_alu_mul_seq.sv - scoreboard bench for alu_mul_seq with a behavioural ALU adder
module tb_alu_mul_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        sign = 1'b0;
   logic [15:0] mcand = '0;
   logic [15:0] mplier = '0;
   logic        busy, done;
   logic [15:0] prod_hi, prod_lo, alu_a, alu_b, alu_out;
   logic [4:0]  alu_op;
   logic        alu_cin, alu_invb, alu_sign, alu_ofl;

   typedef struct {
      logic [31:0] prod;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

`ifdef ALU_MUL_ZERO_SKIP_EN
   localparam int ZLAT = 1;
`else
   localparam int ZLAT = 17;
`endif

   alu_mul_seq dut (
      .clk(clk), .rst_n(rst_n), .start(start), .sign(sign),
      .mcand(mcand), .mplier(mplier), .busy(busy), .done(done),
      .prod_hi(prod_hi), .prod_lo(prod_lo), .alu_a(alu_a), .alu_b(alu_b),
      .alu_op(alu_op), .alu_cin(alu_cin), .alu_invb(alu_invb),
      .alu_sign(alu_sign), .alu_out(alu_out), .alu_ofl(alu_ofl)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // External ALU: A + (invb ? ~B : B) + cin, overflow per alu_sign
   logic [15:0] b_eff;
   logic [16:0] wide;
   always_comb begin
      b_eff   = alu_invb ? ~alu_b : alu_b;
      wide    = {1'b0, alu_a} + {1'b0, b_eff} + {16'd0, alu_cin};
      alu_out = wide[15:0];
      alu_ofl = alu_sign ? ((alu_a[15] == b_eff[15]) && (wide[15] != alu_a[15])) : wide[16];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && done) begin
         if (sb.size() == 0) begin
            chk("spurious_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("product", {prod_hi, prod_lo}, e.prod);
            chk("done_cycle", 32'(cyc), 32'(e.cyc));
         end
      end
   end

   task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic sg,
                        input logic [31:0] exp, input int lat, output int s);
      exp_t e;
      mcand  = a;
      mplier = b;
      sign   = sg;
      start  = 1'b1;
      s      = cyc;
      e.prod = exp;
      e.cyc  = s + lat;
      sb.push_back(e);
   endtask

   task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic sg,
                         input logic [31:0] exp);
      int s;
      @(negedge clk);
      issue(a, b, sg, exp, 17, s);
      @(negedge clk);
      start = 1'b0;
      chk("busy_first", 32'(busy), 32'd1);
      repeat (15) @(negedge clk);
      chk("busy_last", 32'(busy), 32'd1);
      @(negedge clk);
      chk("busy_in_done", 32'(busy), 32'd0);
      @(negedge clk);
   endtask

   initial begin
      int s;
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_prod", {prod_hi, prod_lo}, 32'd0);
      chk("rst_alu_ctl", {30'd0, alu_cin, alu_invb}, 32'd0);
      chk("alu_op", 32'(alu_op), 32'h4);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      run_op(16'h0003, 16'h0005, 1'b0, 32'h0000_000F);
      run_op(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001);
      run_op(16'hFFFF, 16'hFFFF, 1'b1, 32'h0000_0001);
      run_op(16'h8000, 16'h8000, 1'b1, 32'h4000_0000);
      run_op(16'h0007, 16'hFFFD, 1'b1, 32'hFFFF_FFEB);
      run_op(16'h8000, 16'h7FFF, 1'b1, 32'hC000_8000);

      // start held through CALC with changing operands must be ignored
      @(negedge clk);
      issue(16'h00FF, 16'h0101, 1'b0, 32'h0000_FFFF, 17, s);
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         mcand  = 16'hAAAA + 16'(i);
         mplier = 16'h5555;
         sign   = 1'b1;
         if (i == 3) chk("alu_b_holds_m", 32'(alu_b), 32'h00FF);
      end
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);

      // back-to-back: start asserted in the DONE cycle
      @(negedge clk);
      issue(16'h1234, 16'h0010, 1'b0, 32'h0001_2340, 17, s);
      @(negedge clk);
      start = 1'b0;
      repeat (16) @(negedge clk);
      chk("b2b_done_now", 32'(done), 32'd1);
      begin
         int s2;
         issue(16'h0005, 16'hFFFE, 1'b1, 32'hFFFF_FFF6, 17, s2);
         chk("b2b_second_cycle", 32'(s2 + 17 - s), 32'd34);
      end
      @(negedge clk);
      start = 1'b0;
      chk("b2b_busy", 32'(busy), 32'd1);
      repeat (18) @(negedge clk);

      // asynchronous reset at cycle 8 of CALC
      mcand  = 16'hFFFF;
      mplier = 16'hFFFF;
      sign   = 1'b0;
      start  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      chk("pre_reset_busy", 32'(busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_prod", {prod_hi, prod_lo}, 32'd0);
      chk("async_rst_busy", 32'(busy), 32'd0);
      chk("async_rst_done", 32'(done), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      chk("no_done_after_abort", 32'(sb.size()), 32'd0);
      run_op(16'h7FFF, 16'h7FFF, 1'b1, 32'h3FFF_0001);

      // zero operand
      @(negedge clk);
      issue(16'h0000, 16'h1234, 1'b0, 32'h0000_0000, ZLAT, s);
      @(negedge clk);
      start = 1'b0;
      chk("zero_busy", 32'(busy), (ZLAT == 1) ? 32'd0 : 32'd1);
      repeat (20) @(negedge clk);

      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule

// File: doc/alu_mul_seq.md
Name: alu_mul_seq

Overview:
- Multi-cycle 16x16 multiply sequencer that reuses the existing 16-bit ALU adder instead of a dedicated multiplier.
- Drives the ALU operand/control inputs one iteration per cycle: shift-add for unsigned, radix-2 Booth for signed.
- Produces a 32-bit product split into hi and lo words.
- Sits beside the execute stage. The stall logic holds the pipeline on busy; the ALU input mux selects this block's outputs while busy=1.

Parameters:
- WIDTH, 16, operand width; the block is verified only at 16.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE or DONE.
- sign  in  1  1 = signed (two's complement) multiply, 0 = unsigned.
- mcand  in  16  multiplicand M.
- mplier  in  16  multiplier Q.
- busy  out  1  high while iterating.
- done  out  1  one-cycle pulse; product valid.
- prod_hi  out  16  product bits 31:16.
- prod_lo  out  16  product bits 15:0.
- alu_a  out  16  ALU A operand = accumulator.
- alu_b  out  16  ALU B operand = M.
- alu_op  out  5  ALU opcode; constant add 5'b00100.
- alu_cin  out  1  ALU carry in.
- alu_invb  out  1  ALU invert-B.
- alu_sign  out  1  ALU signed-overflow mode; equals the latched sign.
- alu_out  in  16  ALU sum, combinational from alu_a/alu_b.
- alu_ofl  in  1  ALU overflow: signed overflow when alu_sign=1, carry-out when alu_sign=0.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all registers (accumulator ACC, Q, Q_1, counter, latched M, latched sign) =0.
  - busy=0, done=0, prod_hi=prod_lo=0, alu_cin=0, alu_invb=0.
- Reset asserted mid-operation aborts immediately. No done pulse; product reads 0.
- States IDLE, CALC, DONE:
  - IDLE/DONE with start=1: latch M=mcand, Q=mplier, sign; ACC=0, Q_1=0, cnt=0; go to CALC.
  - IDLE/DONE with start=0: DONE goes to IDLE; IDLE stays.
  - CALC: one iteration per cycle; cnt increments. On the edge completing iteration 16 (cnt==15), go to DONE.
- Latency: start high in cycle 0; busy=1 in cycles 1-16; done=1 in cycle 17 only.
- prod_hi/prod_lo = {ACC,Q}. They hold their value in IDLE/DONE until the next accepted start clears them.
- Unsigned iteration (sign=0):
  - Q[0]=1: alu_invb=0, alu_cin=0, sum = alu_out, carry = alu_ofl.
  - Q[0]=0: sum = ACC, carry = 0; ALU output ignored.
  - {ACC,Q} <= {carry, sum, Q} >> 1, keeping the upper 32 bits.
- Signed iteration (Booth, sign=1), on {Q[0],Q_1}:
  - 01: add, alu_invb=0, alu_cin=0.
  - 10: subtract, alu_invb=1, alu_cin=1.
  - 00/11: no add; sum = ACC, true sign = ACC[15].
  - After an add/subtract: sum = alu_out, true sign = alu_out[15]^alu_ofl. This corrects overflow, e.g. M=0x8000.
  - Arithmetic shift right: {ACC,Q,Q_1} <= {truesign, sum, Q}.
- alu_a=ACC and alu_b=M at all times. alu_op is constant 5'b00100. Outside CALC, alu_cin=alu_invb=0.
- start while busy is ignored: no restart, operands not re-latched.
- start sampled in DONE starts a new operation back-to-back. done still pulses for the finishing operation.

Optional Feature:
- Macro: ALU_MUL_ZERO_SKIP_EN.
- Defined: if mcand==0 or mplier==0 when start is accepted, go straight to DONE. Product 0, done in cycle 1, busy never asserted.
- Undefined: all operations take the full 16 iterations.

Decomposition:
- Package alu_mul_pkg holds:
  - state enum {IDLE, CALC, DONE};
  - ALU_OP_ADD = 5'b00100;
  - MUL_ITER = 16.
- No sub-module. The ALU is instantiated outside; the execute stage muxes its inputs.

Test Plan:
- Unsigned 3 x 5, start pulse in cycle 0 -> busy cycles 1-16, done in cycle 17, prod_hi=0x0000, prod_lo=0x000F.
- Unsigned 0xFFFF x 0xFFFF -> prod_hi=0xFFFE, prod_lo=0x0001. This checks the carry path via alu_ofl.
- Signed cases:
  - 0xFFFF x 0xFFFF -> 0x0000_0001;
  - 0x8000 x 0x8000 -> 0x4000_0000 (overflow correction);
  - 0x0007 x 0xFFFD -> 0xFFFF_FFEB.
- start held high during CALC with new operands -> ignored, original product returned. start high in the DONE cycle -> second operation starts, second done in cycle 34.
- rst_n driven low at cycle 8 of CALC -> outputs 0 asynchronously, IDLE. A fresh start afterwards gives a correct product.
- With ALU_MUL_ZERO_SKIP_EN: 0 x 0x1234 -> done in cycle 1, product 0, busy stays 0. Without it, done in cycle 17.
